// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with blank, hsync, vsync and a
// frame-wrap pulse, advancing one pixel per clk in which pix_en is high.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [10:0] hc,
  output logic [10:0] vc,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] hc_nxt;
  logic [10:0] vc_nxt;

  // Sync level for a counter position: asserted level inside [lo, hi).
  function automatic logic sync_level(input logic [10:0] c,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
    return (c >= lo && c < hi) ? SYNC_POL : ~SYNC_POL;
  endfunction

  always_comb begin
    h_wrap = (hc == H_LAST);
    v_wrap = (vc == V_LAST);
    hc_nxt = h_wrap ? 11'd0 : hc + 11'd1;
    vc_nxt = vc;
    if (h_wrap) begin
      vc_nxt = v_wrap ? 11'd0 : vc + 11'd1;
    end
  end

  // Decodes are taken from the next-state counters so they stay aligned with hc/vc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc          <= 11'd0;
      vc          <= 11'd0;
      blank       <= 1'b0;
      hs          <= ~SYNC_POL;
      vs          <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        hc          <= hc_nxt;
        vc          <= vc_nxt;
        blank       <= (hc_nxt >= H_VIS) | (vc_nxt >= V_VIS);
        hs          <= sync_level(hc_nxt, HS_START, HS_END);
        vs          <= sync_level(vc_nxt, VS_START, VS_END);
        frame_start <= h_wrap & v_wrap;
      end
    end
  end

endmodule
